seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl_dec.sv | 28 ++
 rtl/seg7_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_dec.sv
// Shared 7-segment decoder: BCD nibble to active-low {g,f,e,d,c,b,a}.
// A disabled digit is fully dark; non-BCD codes light every segment.
module seg7_scan_ctrl_dec (
   input  logic [3:0] nib,
   input  logic       en,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = 7'b1111111;
      if (en) begin
         case (nib)
            4'd0:    seg_n = 7'b1000000;
            4'd1:    seg_n = 7'b1111001;
            4'd2:    seg_n = 7'b0100100;
            4'd3:    seg_n = 7'b0110000;
            4'd4:    seg_n = 7'b0011001;
            4'd5:    seg_n = 7'b0010010;
            4'd6:    seg_n = 7'b0000010;
            4'd7:    seg_n = 7'b1111000;
            4'd8:    seg_n = 7'b0000000;
            4'd9:    seg_n = 7'b0010000;
            default: seg_n = 7'b0000000;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner with per-slot blanking guard,
// per-digit blink and leading-zero blanking of the hours-tens digit.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 83
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [23:0] DIN,
   input  logic [5:0]  BLINK,
   input  logic        LZB,
   output logic [6:0]  nHEX,
   output logic [5:0]  nDIGIT
);

   localparam int NDIG = 6;
   localparam int IW   = $clog2(NDIG);
   localparam int CW   = $clog2(SCAN_DIV);
   localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]   CNT_ON   = CW'(GUARD);
   localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
   localparam logic [FW-1:0]   FRM_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [NDIG-1:0] SEL_ONE  = {{(NDIG-1){1'b0}}, 1'b1};

   typedef enum logic {S_GUARD, S_ON} slot_t;

   logic [CW-1:0]   cnt, cnt_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic [FW-1:0]   frame;
   logic            phase;
   logic [3:0]      nib, cur_dig;
   logic            en;
   logic            slot_end, frame_end, blank;
   slot_t           state;
   logic [NDIG-1:0] ndig;

   always_comb begin
      slot_end  = (cnt == CNT_LAST);
      frame_end = slot_end && (idx == IDX_LAST);
      cnt_nxt   = slot_end ? '0 : cnt + 1'b1;

      idx_nxt = idx;
      if (slot_end)
         idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

      cur_dig = DIN[3:0];
      case (idx)
         IW'(1):  cur_dig = DIN[7:4];
         IW'(2):  cur_dig = DIN[11:8];
         IW'(3):  cur_dig = DIN[15:12];
         IW'(4):  cur_dig = DIN[19:16];
         IW'(5):  cur_dig = DIN[23:20];
         default: cur_dig = DIN[3:0];
      endcase

      // Leading-zero test looks at the hours-tens digit itself, not at nib.
      blank = (BLINK[idx] & phase)
            | (LZB & (idx == IDX_LAST) & (DIN[4*NDIG-1 -: 4] == 4'd0));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt   <= '0;
         idx   <= '0;
         frame <= '0;
         phase <= 1'b0;
         nib   <= 4'd0;
         en    <= 1'b0;
         state <= S_GUARD;
         ndig  <= '1;
      end else begin
         cnt <= cnt_nxt;
         idx <= idx_nxt;

         // Phase flips together with the 5->0 wrap so the new frame starts clean.
         if (frame_end) begin
            if (frame == FRM_LAST) begin
               frame <= '0;
               phase <= ~phase;
            end else begin
               frame <= frame + 1'b1;
            end
         end

         // Latch the slot's digit once; segments settle while the digit is dark.
         if (cnt == '0) begin
            nib <= cur_dig;
            en  <= ~blank;
         end

         case (state)
            S_GUARD: if (cnt_nxt == CNT_ON) begin
               state <= S_ON;
               ndig  <= ~(SEL_ONE << idx);
            end
            S_ON: if (slot_end) begin
               state <= S_GUARD;
               ndig  <= '1;
            end
         endcase
      end
   end

   assign nDIGIT = ndig;

   seg7_scan_ctrl_dec u_dec (
      .nib   (nib),
      .en    (en),
      .seg_n (nHEX)
   );

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl: an arithmetic model of slot/frame
// timing checked every cycle, plus literal expectations for the key scenarios.
module tb_seg7_scan_ctrl;

   localparam int SD = 8;
   localparam int GD = 2;
   localparam int BF = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [23:0] DIN = 24'h0;
   logic [5:0]  BLINK = 6'h0;
   logic        LZB = 1'b0;
   logic [6:0]  nHEX;
   logic [5:0]  nDIGIT;

   int checks = 0;
   int errors = 0;

   int unsigned t = 0;
   logic        started = 1'b0;
   logic [6:0]  shown = 7'h7F;
   logic [6:0]  prev_hex = 7'h7F;
   logic [5:0]  prev_dig = 6'h3F;

   seg7_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .DIN    (DIN),
      .BLINK  (BLINK),
      .LZB    (LZB),
      .nHEX   (nHEX),
      .nDIGIT (nDIGIT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0000000;
      endcase
   endfunction

   // What the slot starting at absolute cycle tt must show, given current inputs.
   function automatic logic [6:0] model_seg(input int unsigned tt);
      int unsigned ix, fr, ph;
      logic [3:0] d;
      logic blank;
      ix = (tt / SD) % 6;
      fr = tt / (SD * 6);
      ph = (fr / BF) % 2;
      d  = DIN[4*ix +: 4];
      blank = (BLINK[ix] && ph == 1) || (LZB && ix == 5 && DIN[23:20] == 4'd0);
      return blank ? 7'h7F : dec7(d);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", nm, act, exp, t, $time);
      end
   endtask

   always @(posedge CLK) begin
      if (RST) begin
         t = 0;
         shown = 7'h7F;
         started = 1'b1;
      end else if (started) begin
         if (t % SD == 0) shown = model_seg(t);
         t++;
      end
   end

   always @(negedge CLK) begin
      if (started) begin
         int unsigned c, ix;
         logic [5:0] expd;
         c  = t % SD;
         ix = (t / SD) % 6;
         expd = (c < GD) ? 6'h3F : ~(6'b000001 << ix);
         chk("ndigit_model", {26'd0, nDIGIT}, {26'd0, expd});
         chk("nhex_model", {25'd0, nHEX}, {25'd0, shown});
         chk("onehot_low", ($countones(~nDIGIT) <= 1) ? 32'd1 : 32'd0, 32'd1);
         if (nDIGIT != 6'h3F && prev_dig != 6'h3F)
            chk("nhex_stable_lit", {25'd0, nHEX}, {25'd0, prev_hex});
         prev_hex = nHEX;
         prev_dig = nDIGIT;
      end
   end

   task automatic do_reset();
      @(posedge CLK); #2;
      RST = 1'b1;
      @(posedge CLK); #2;
      RST = 1'b0;
   endtask

   task automatic at_cycle(input int unsigned k);
      int n;
      n = 0;
      @(negedge CLK);
      while (t != k && n < 200000) begin
         @(negedge CLK);
         n++;
      end
      if (t != k) begin
         checks++;
         errors++;
         $display("FAIL at_cycle_timeout: got t=%0d expected t=%0d", t, k);
      end
   endtask

   initial begin
      // Scan order and basic decode.
      DIN = 24'h235959; BLINK = 6'h00; LZB = 1'b0;
      do_reset();
      at_cycle(0);  chk("rst_ndig", nDIGIT, 6'b111111); chk("rst_nhex", nHEX, 7'b1111111);
      at_cycle(1);  chk("guard1_ndig", nDIGIT, 6'b111111);
      at_cycle(2);  chk("d0_ndig", nDIGIT, 6'b111110); chk("d0_nhex", nHEX, 7'b0010000);
      at_cycle(7);  chk("d0_end_ndig", nDIGIT, 6'b111110);
      at_cycle(8);  chk("d1_guard", nDIGIT, 6'b111111);
      at_cycle(10); chk("d1_ndig", nDIGIT, 6'b111101); chk("d1_nhex", nHEX, 7'b0010010);
      at_cycle(42); chk("d5_ndig", nDIGIT, 6'b011111); chk("d5_nhex", nHEX, 7'b0100100);
      at_cycle(50); chk("d0_rep_ndig", nDIGIT, 6'b111110); chk("d0_rep_nhex", nHEX, 7'b0010000);

      // Blink on digits 0 and 1, BLINK_FRAMES = 2.
      BLINK = 6'b000011;
      do_reset();
      at_cycle(2);   chk("blk_f0_d0", nHEX, 7'b0010000);
      at_cycle(58);  chk("blk_f1_d1", nHEX, 7'b0010010);
      at_cycle(98);  chk("blk_f2_d0", nHEX, 7'b1111111);
      at_cycle(106); chk("blk_f2_d1", nHEX, 7'b1111111);
      at_cycle(114); chk("blk_f2_d2_ndig", nDIGIT, 6'b111011); chk("blk_f2_d2", nHEX, 7'b0010000);
      at_cycle(146); chk("blk_f3_d0", nHEX, 7'b1111111);
      at_cycle(194); chk("blk_f4_d0", nHEX, 7'b0010000);
      BLINK = 6'h00;

      // Leading-zero blank.
      DIN = 24'h012345; LZB = 1'b1;
      do_reset();
      at_cycle(42); chk("lzb_ndig", nDIGIT, 6'b011111); chk("lzb_nhex", nHEX, 7'b1111111);
      LZB = 1'b0;
      do_reset();
      at_cycle(42); chk("nolzb_nhex", nHEX, 7'b1000000);

      // Input change mid-slot is ignored until the next capture.
      DIN = 24'h000000;
      do_reset();
      at_cycle(2);
      @(posedge CLK); #2;
      DIN = 24'h000001;
      at_cycle(5);  chk("midslot_hold", nHEX, 7'b1000000);
      at_cycle(50); chk("midslot_next", nHEX, 7'b1111001);

      // Reset pulse while digit 3 is lit.
      DIN = 24'h987654;
      do_reset();
      at_cycle(28); chk("d3_on", nDIGIT, 6'b110111);
      @(posedge CLK); #2;
      RST = 1'b1;
      @(posedge CLK); #2;
      RST = 1'b0;
      at_cycle(0);  chk("abort_ndig", nDIGIT, 6'b111111); chk("abort_nhex", nHEX, 7'b1111111);
      at_cycle(2);  chk("resume_ndig", nDIGIT, 6'b111110); chk("resume_nhex", nHEX, 7'b0011001);

      // Long randomized run; the per-cycle model does the checking.
      for (int n = 0; n < 48000; n++) begin
         @(posedge CLK); #2;
         if ($urandom_range(15) == 0) begin
            logic [23:0] v;
            v = $urandom;
            for (int k = 0; k < 6; k++)
               if ($urandom_range(7) != 0) v[4*k +: 4] = 4'($urandom_range(9));
            if ($urandom_range(3) == 0) v[23:20] = 4'd0;
            DIN = v;
         end
         if ($urandom_range(199) == 0) begin
            BLINK = 6'($urandom);
            LZB   = 1'($urandom);
         end
         if ($urandom_range(9999) == 0) RST = 1'b1;
         else RST = 1'b0;
      end
      RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
